jtframe_ddr_arb: RTL
====================

JTFRAME_DDR_ARB -- requirements
Module: jtframe_ddr_arb

Interface
REQ-001 SHALL have parameter MAXWAIT, default 64: cycles m1 may wait while m0 keeps winning before m1 is forced to win.
REQ-002 SHALL have port clk, input, 1: single clock for all logic; also drives ddram_clk.
REQ-003 SHALL have port rst_n, input, 1: reset, synchronous to clk, active-low.
REQ-004 SHALL have ports mN_addr[31:3], mN_burstcnt[7:0], mN_rd, mN_we, mN_din[63:0], mN_be[7:0], all inputs, for N=0 (real-time line buffer) and N=1 (background requester).
REQ-005 SHALL have ports mN_busy (output, 1), mN_dout (output, 64) and mN_dout_ready (output, 1), for N=0,1.
REQ-006 SHALL have DDR-side ports ddram_clk, ddram_addr[31:3], ddram_burstcnt[7:0], ddram_rd, ddram_we, ddram_din[63:0] and ddram_be[7:0] as outputs.
REQ-007 SHALL have DDR-side ports ddram_busy, ddram_dout[63:0] and ddram_dout_ready as inputs.
REQ-008 SHALL have port st_addr[7:0] (input) and st_dout[7:0] (registered output) for status readback.

Function
REQ-009 SHALL implement states IDLE, GNT0, GNT1; the owner is 0 in GNT0 and 1 in GNT1.
REQ-010 In IDLE, ddram_rd and ddram_we SHALL be 0, and both mN_busy SHALL be 1.
REQ-011 A master requests by asserting mN_rd or mN_we and holding it, with its other signals, while mN_busy=1.
REQ-012 In IDLE with requests sampled, the arbiter SHALL enter GNT0 if m0 requests and the m1 wait counter is below MAXWAIT; otherwise it SHALL enter GNT1 if m1 requests. Grant latency is 1 cycle.
REQ-013 When forced by MAXWAIT, m1 SHALL be granted even if m0 is also requesting.
REQ-014 The m1 wait counter SHALL increment each cycle m1 requests and is not owner, SHALL saturate at MAXWAIT, and SHALL clear when GNT1 is entered.
REQ-015 While granted, ddram_addr, burstcnt, rd, we, din and be SHALL pass through combinationally from the owner, and owner busy SHALL equal ddram_busy; the non-owner's busy SHALL be 1.
REQ-016 A command is accepted when (ddram_rd|ddram_we) & ~ddram_busy; on acceptance the arbiter SHALL latch the beat count beats=burstcnt, with 0 treated as 1.
REQ-017 If the owner asserts rd and we together, rd SHALL be forwarded and we forced to 0 until the read completes.
REQ-018 For a read, owner busy SHALL be forced to 1 after acceptance, and the grant SHALL be released when the beats-th ddram_dout_ready is counted.
REQ-019 For a write, the first beat is the acceptance; every later we&~busy counts one beat, and the grant SHALL be released on the beats-th beat.
REQ-020 The release transition SHALL go to IDLE, giving at least 1 idle cycle between grants.
REQ-021 ddram_dout SHALL be routed to both mN_dout; mN_dout_ready = ddram_dout_ready & (owner==N) & read-in-progress.
REQ-022 ddram_dout_ready outside a read grant SHALL be ignored and counted in an 8-bit saturating error counter.
REQ-023 The beat counter SHALL be 9 bits so that 256 beats is representable without wrap.
REQ-024 st_dout SHALL give: addr 0 = {2'b0, state[1:0], m1_req, m0_req, ddram_busy, ddram_dout_ready}; 1 = beat count [7:0]; 2 = m1 wait counter [7:0] (saturated); 3 = error counter; other addresses = 0.

Reset
REQ-025 With rst_n=0 at a clk edge: state=IDLE, counters=0, st_dout=0; ddram_rd and ddram_we SHALL be 0 and both mN_busy SHALL be 1 the same cycle.
REQ-026 On reset mid-burst the arbiter SHALL drop the grant with no further handshake; any outstanding DDR beats SHALL be counted as errors.

Structure
REQ-027 State encodings, MAXWAIT default and status address map SHALL live in shared package jtframe_ddr_arb_pkg.
REQ-028 An optional sub-module jtframe_ddr_arb_cnt SHALL hold the beat counter and the completion flag; everything else SHALL be flat.

Verification
REQ-029 m0 reads burstcnt=0x80 with ddram_busy=0: grant 1 cycle later; 128 m0_dout_ready pulses; m1_dout_ready stays 0; IDLE after the 128th.
REQ-030 m0 and m1 request in the same cycle: m0 is served first; GNT1 starts 2 cycles after m0's last beat.
REQ-031 m0 issues continuous back-to-back requests while m1 waits, MAXWAIT=64: m1 is granted at the first IDLE after its wait counter reaches 64.
REQ-032 m1 writes burstcnt=4 with ddram_busy toggling every cycle: exactly 4 beats are forwarded, then release.
REQ-033 rst_n pulled low at beat 10 of a 128-beat read: IDLE next cycle; 118 stray beats give error count 118.
REQ-034 burstcnt=0 write: treated as 1 beat; release after a single accepted we.

Source files
------------

// File: rtl/jtframe_ddr_arb_pkg.sv
// Shared types and constants for the two-master DDR arbiter: state encoding,
// default starvation limit, status readback map and burst-length helper.
package jtframe_ddr_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } arb_state_e;

    localparam int unsigned MAXWAIT_DEF = 64;
    localparam int unsigned BEATW       = 9;

    localparam logic [7:0] ST_ADDR_FLAGS = 8'd0;
    localparam logic [7:0] ST_ADDR_BEATS = 8'd1;
    localparam logic [7:0] ST_ADDR_WAIT  = 8'd2;
    localparam logic [7:0] ST_ADDR_ERR   = 8'd3;

    // A burst count of zero still moves one beat.
    function automatic logic [BEATW-1:0] burst_beats(input logic [7:0] burstcnt);
        return (burstcnt == 8'd0) ? BEATW'(1) : BEATW'(burstcnt);
    endfunction

endpackage

// File: rtl/jtframe_ddr_arb_cnt.sv
// Beat counter for the current grant; flags the beat that completes the burst.
module jtframe_ddr_arb_cnt
    import jtframe_ddr_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             first_i,
    input  logic [BEATW-1:0] beats_i,
    input  logic             beat_i,
    output logic [BEATW-1:0] cnt_o,
    output logic             last_c_o
);

    logic [BEATW-1:0] cnt_q, cnt_d;
    logic [BEATW-1:0] total_q, total_d;

    // A write acceptance is itself the first beat, so it may also be the last.
    always_comb begin
        cnt_d    = cnt_q;
        total_d  = total_q;
        last_c_o = 1'b0;
        if (load_i) begin
            total_d  = beats_i;
            cnt_d    = first_i ? BEATW'(1) : '0;
            last_c_o = first_i && (beats_i == BEATW'(1));
        end else if (beat_i) begin
            cnt_d    = cnt_q + BEATW'(1);
            last_c_o = (cnt_d == total_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            total_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            total_q <= total_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/jtframe_ddr_arb.sv
// Two-master DDR arbiter: m0 (real-time) has priority, m1 is forced in after
// waiting MAXWAIT cycles. Owner signals pass straight through while granted.
module jtframe_ddr_arb
    import jtframe_ddr_arb_pkg::*;
#(
    parameter int unsigned MAXWAIT = MAXWAIT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [31:3] m0_addr,
    input  logic [7:0]  m0_burstcnt,
    input  logic        m0_rd,
    input  logic        m0_we,
    input  logic [63:0] m0_din,
    input  logic [7:0]  m0_be,
    output logic        m0_busy,
    output logic [63:0] m0_dout,
    output logic        m0_dout_ready,

    input  logic [31:3] m1_addr,
    input  logic [7:0]  m1_burstcnt,
    input  logic        m1_rd,
    input  logic        m1_we,
    input  logic [63:0] m1_din,
    input  logic [7:0]  m1_be,
    output logic        m1_busy,
    output logic [63:0] m1_dout,
    output logic        m1_dout_ready,

    output logic        ddram_clk,
    output logic [31:3] ddram_addr,
    output logic [7:0]  ddram_burstcnt,
    output logic        ddram_rd,
    output logic        ddram_we,
    output logic [63:0] ddram_din,
    output logic [7:0]  ddram_be,
    input  logic        ddram_busy,
    input  logic [63:0] ddram_dout,
    input  logic        ddram_dout_ready,

    input  logic [7:0]  st_addr,
    output logic [7:0]  st_dout
);

    localparam int unsigned WAITW = $clog2(MAXWAIT + 1);

    arb_state_e       state_q, state_d;
    logic             rd_inprog_q, rd_inprog_d;
    logic             wr_inprog_q, wr_inprog_d;
    logic [WAITW-1:0] wait_q, wait_d;
    logic [7:0]       err_q, err_d;
    logic [7:0]       st_dout_q, st_dout_d;

    logic m0_req, m1_req, own0_act, own1_act, granted;
    logic own_rd, own_we, own_busy, accept, rd_beat, wr_beat, last_c;
    logic [BEATW-1:0] beat_cnt;

    assign m0_req   = m0_rd | m0_we;
    assign m1_req   = m1_rd | m1_we;
    // Reset gates the grant immediately so no command leaks during reset.
    assign own0_act = rst_n & (state_q == ST_GNT0);
    assign own1_act = rst_n & (state_q == ST_GNT1);
    assign granted  = own0_act | own1_act;

    assign own_rd         = own1_act ? m1_rd       : m0_rd;
    assign own_we         = own1_act ? m1_we       : m0_we;
    assign ddram_addr     = own1_act ? m1_addr     : m0_addr;
    assign ddram_burstcnt = own1_act ? m1_burstcnt : m0_burstcnt;
    assign ddram_din      = own1_act ? m1_din      : m0_din;
    assign ddram_be       = own1_act ? m1_be       : m0_be;
    assign ddram_clk      = clk;

    // Once a read is accepted the held request must not re-issue; rd wins over we.
    assign ddram_rd = granted & own_rd & ~rd_inprog_q;
    assign ddram_we = granted & own_we & ~own_rd & ~rd_inprog_q;
    assign accept   = (ddram_rd | ddram_we) & ~ddram_busy;
    assign own_busy = ddram_busy | rd_inprog_q;
    assign m0_busy  = ~own0_act | own_busy;
    assign m1_busy  = ~own1_act | own_busy;

    assign rd_beat       = granted & rd_inprog_q & ddram_dout_ready;
    assign wr_beat       = ddram_we & ~ddram_busy & wr_inprog_q;
    assign m0_dout       = ddram_dout;
    assign m1_dout       = ddram_dout;
    assign m0_dout_ready = rd_beat & own0_act;
    assign m1_dout_ready = rd_beat & own1_act;

    jtframe_ddr_arb_cnt u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (accept & ~wr_inprog_q),
        .first_i  (ddram_we),
        .beats_i  (burst_beats(ddram_burstcnt)),
        .beat_i   (rd_beat | wr_beat),
        .cnt_o    (beat_cnt),
        .last_c_o (last_c)
    );

    // Next-state, starvation counter, stray-beat counter and status mux.
    always_comb begin
        state_d     = state_q;
        rd_inprog_d = rd_inprog_q;
        wr_inprog_d = wr_inprog_q;
        wait_d      = wait_q;
        err_d       = err_q;
        st_dout_d   = 8'd0;

        case (state_q)
            ST_IDLE: begin
                if (m0_req && (wait_q < WAITW'(MAXWAIT))) state_d = ST_GNT0;
                else if (m1_req)                            state_d = ST_GNT1;
            end
            ST_GNT0, ST_GNT1: begin
                if (accept && !wr_inprog_q) begin
                    rd_inprog_d = ddram_rd;
                    wr_inprog_d = ddram_we;
                end
                if (last_c) begin
                    state_d     = ST_IDLE;
                    rd_inprog_d = 1'b0;
                    wr_inprog_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (m1_req && !own1_act && (wait_q < WAITW'(MAXWAIT))) wait_d = wait_q + WAITW'(1);
        if ((state_q == ST_IDLE) && (state_d == ST_GNT1))      wait_d = '0;

        if (ddram_dout_ready && !rd_beat && (err_q != 8'hff)) err_d = err_q + 8'd1;

        case (st_addr)
            ST_ADDR_FLAGS: st_dout_d = {2'b00, 2'(state_q), m1_req, m0_req,
                                        ddram_busy, ddram_dout_ready};
            ST_ADDR_BEATS: st_dout_d = beat_cnt[7:0];
            ST_ADDR_WAIT:  st_dout_d = 8'(wait_q);
            ST_ADDR_ERR:   st_dout_d = err_q;
            default:       st_dout_d = 8'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rd_inprog_q <= 1'b0;
            wr_inprog_q <= 1'b0;
            wait_q      <= '0;
            err_q       <= 8'd0;
            st_dout_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            rd_inprog_q <= rd_inprog_d;
            wr_inprog_q <= wr_inprog_d;
            wait_q      <= wait_d;
            err_q       <= err_d;
            st_dout_q   <= st_dout_d;
        end
    end

    assign st_dout = st_dout_q;

endmodule
